io_port_unit: RTL and testbench
===============================

Name: io_port_unit

Overview:
Memory-mapped-free I/O responder that services the control unit's `in` and `out` instruction states (opcode 4'b1100, funk selects direction).
- Processor side: `OutputWrite` pulses push register data into a TX FIFO. `InputRead` pops the RX FIFO, whose head feeds the register-file write mux (MemtoReg = 2'b10).
- External side: the unit drives a valid/ready stream outward and accepts a valid/ready stream inward.

Parameters:
- WIDTH, 16: datapath/word width, matches register width.
- DEPTH, 4: entries per FIFO; power of two, at least 2.
- PTR_W, 2: log2(DEPTH).

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- OutputWrite  in  1  one-cycle strobe from control unit `out` state; push OutData.
- OutData  in  WIDTH  register B value to transmit.
- InputRead  in  1  one-cycle strobe from control unit `in` state; pop RX head.
- InData  out  WIDTH  RX FIFO head; 0 when RX empty.
- InAvail  out  1  RX FIFO non-empty.
- OutFull  out  1  TX FIFO holds DEPTH words.
- ext_tx_data  out  WIDTH  TX FIFO head.
- ext_tx_valid  out  1  TX FIFO non-empty.
- ext_tx_ready  in  1  external sink accepts word.
- ext_rx_data  in  WIDTH  incoming word.
- ext_rx_valid  in  1  incoming word valid.
- ext_rx_ready  out  1  RX FIFO can accept.
- OverflowErr  out  1  sticky: OutputWrite dropped.
- UnderflowErr  out  1  sticky: InputRead on empty RX.
- err_clear  in  1  clears both sticky flags.

Behaviour:
- **Reset (Reset_n low, async):**
  - All pointers and counts 0; FIFO contents discarded.
  - OverflowErr = UnderflowErr = 0, ext_tx_valid = 0, InAvail = 0, OutFull = 0, InData = 0.
  - ext_rx_ready forced 0 while Reset_n is low; 1 on the first cycle after release.
  - Reset mid-transfer drops any in-flight word; no partial state survives.
- **TX FIFO (circular buffer, wr_ptr/rd_ptr PTR_W bits wrapping DEPTH-1 -> 0, count 0..DEPTH):**
  - Pop when ext_tx_valid && ext_tx_ready.
  - Push when OutputWrite && (!OutFull || pop in same cycle). Full with simultaneous pop: word accepted, count stays DEPTH.
  - OutputWrite with OutFull and no pop: word dropped, pointers unchanged, OverflowErr set next edge.
  - Latency: word pushed at edge N drives ext_tx_valid/ext_tx_data from edge N onward (empty case).
  - ext_tx_data is held stable while ext_tx_valid && !ext_tx_ready.
  - Words leave in push order.
- **RX FIFO (same structure):**
  - ext_rx_ready = !(count == DEPTH) after reset. It is derived from registered count only, with no same-cycle pop bypass.
  - Push when ext_rx_valid && ext_rx_ready.
  - InData = head combinationally when InAvail, else all zeros.
  - InputRead && InAvail: pop at edge; the register file captures InData in that same cycle.
  - InputRead && !InAvail: no pointer change; UnderflowErr set next edge. The processor writes 0.
  - Simultaneous push and InputRead on empty: no bypass. InData = 0, underflow flagged, pushed word stored (count 1).
  - Simultaneous push and pop, non-empty: count unchanged, both pointers advance.
- **Sticky errors:**
  - Set by the event and held until err_clear.
  - err_clear and a new error event in the same cycle: flag stays set (set wins).
- **Counts and status:**
  - Counts are PTR_W+1 bits; no arithmetic overflow possible by construction.
  - InAvail and OutFull are decoded from registered counts.

Test Plan:
- **Reset:** hold Reset_n = 0 mid-run -> all outputs 0 including ext_rx_ready; release -> ext_rx_ready = 1, InAvail = 0, ext_tx_valid = 0.
- **TX ordering and backpressure:**
  - OutputWrite with 16'h0011, 16'h0022, 16'h0033, ext_tx_ready = 0 -> ext_tx_valid = 1, ext_tx_data = 16'h0011 stable.
  - Then ext_tx_ready = 1 for 3 cycles -> 0011, 0022, 0033 in order, then ext_tx_valid = 0.
- **TX overflow and wrap:**
  - 5 OutputWrites (0xA0..0xA4) with ready = 0 -> OutFull = 1 after 4th; 0xA4 dropped; OverflowErr = 1.
  - Drain -> A0..A3.
  - Then 6 more words with ready = 1 exercise pointer wrap; outputs in order.
- **Full with simultaneous push/pop:**
  - TX full, ready = 1 and OutputWrite 16'hBEEF same cycle -> no OverflowErr, count stays 4.
  - 16'hBEEF emerges 4th after.
- **RX path:**
  - Push 16'h1234, 16'h5678 -> InAvail = 1, InData = 16'h1234.
  - InputRead -> InData = 16'h5678.
  - InputRead -> InAvail = 0, InData = 0.
  - InputRead again -> UnderflowErr = 1.
  - 4 pushes with no reads -> ext_rx_ready = 0; 5th valid held until a read frees a slot.
- **Error clear priority:** err_clear and empty InputRead in the same cycle -> UnderflowErr remains 1; err_clear alone next cycle -> 0.

Source files
------------

// File: rtl/io_port_if.sv
// io_port_if: groups the processor-side strobes, the outbound and inbound
// valid/ready streams, and the sticky error flags of io_port_unit.
//   master : the environment (control unit, external peer, error clear)
//   slave  : io_port_unit itself
// Signals:
//   OutputWrite/OutData : push a word into the TX FIFO
//   InputRead/InData    : pop the RX FIFO head (InData is 0 when empty)
//   InAvail/OutFull     : RX non-empty / TX full status
//   ext_tx_*            : outbound stream (unit is the source)
//   ext_rx_*            : inbound stream (unit is the sink)
//   OverflowErr/UnderflowErr/err_clear : sticky error flags and their clear
interface io_port_if #(
  parameter int WIDTH = 16
);
  logic             OutputWrite;
  logic [WIDTH-1:0] OutData;
  logic             InputRead;
  logic [WIDTH-1:0] InData;
  logic             InAvail;
  logic             OutFull;
  logic [WIDTH-1:0] ext_tx_data;
  logic             ext_tx_valid;
  logic             ext_tx_ready;
  logic [WIDTH-1:0] ext_rx_data;
  logic             ext_rx_valid;
  logic             ext_rx_ready;
  logic             OverflowErr;
  logic             UnderflowErr;
  logic             err_clear;

  modport master (
    output OutputWrite, OutData, InputRead, ext_tx_ready,
           ext_rx_data, ext_rx_valid, err_clear,
    input  InData, InAvail, OutFull, ext_tx_data, ext_tx_valid,
           ext_rx_ready, OverflowErr, UnderflowErr
  );

  modport slave (
    input  OutputWrite, OutData, InputRead, ext_tx_ready,
           ext_rx_data, ext_rx_valid, err_clear,
    output InData, InAvail, OutFull, ext_tx_data, ext_tx_valid,
           ext_rx_ready, OverflowErr, UnderflowErr
  );
endinterface

// File: rtl/io_port_unit.sv
// io_port_unit: I/O responder for the control unit's `in`/`out` instructions.
// A TX FIFO buffers words written by `out` and streams them to an external
// sink; an RX FIFO collects words from an external source and presents its
// head to the register-file write mux for `in`.
// Ports:
//   CLK     : system clock, rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : io_port_if slave modport (strobes, streams, status, errors)
module io_port_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        CLK,
  input  logic        Reset_n,
  io_port_if.slave    bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  // TX FIFO state
  logic [WIDTH-1:0] txMem [DEPTH];
  logic [PTR_W-1:0] txWrPtr, txRdPtr;
  logic [PTR_W:0]   txCount;

  // RX FIFO state
  logic [WIDTH-1:0] rxMem [DEPTH];
  logic [PTR_W-1:0] rxWrPtr, rxRdPtr;
  logic [PTR_W:0]   rxCount;

  logic overflowQ, underflowQ;

  logic txValid, txFull, txPop, txPush, txDrop;
  logic rxAvail, rxReady, rxPush, rxPop, rxUnder;

  // Status decoded from registered counts only.
  assign txValid = (txCount != '0);
  assign txFull  = (txCount == FULL_CNT);
  assign rxAvail = (rxCount != '0);
  // Held low while reset is asserted even though the count is already 0.
  assign rxReady = Reset_n && (rxCount != FULL_CNT);

  assign txPop   = txValid && bus.ext_tx_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign txPush  = bus.OutputWrite && (!txFull || txPop);
  assign txDrop  = bus.OutputWrite && txFull && !txPop;

  assign rxPush  = bus.ext_rx_valid && rxReady;
  assign rxPop   = bus.InputRead && rxAvail;
  // No bypass: a read on an empty FIFO underflows even if a word arrives now.
  assign rxUnder = bus.InputRead && !rxAvail;

  assign bus.ext_tx_valid = txValid;
  assign bus.ext_tx_data  = txValid ? txMem[txRdPtr] : '0;
  assign bus.OutFull      = txFull;
  assign bus.InAvail      = rxAvail;
  assign bus.InData       = rxAvail ? rxMem[rxRdPtr] : '0;
  assign bus.ext_rx_ready = rxReady;
  assign bus.OverflowErr  = overflowQ;
  assign bus.UnderflowErr = underflowQ;

  // Storage arrays carry no reset; pointers and counts define validity.
  always_ff @(posedge CLK) begin
    if (txPush) txMem[txWrPtr] <= bus.OutData;
    if (rxPush) rxMem[rxWrPtr] <= bus.ext_rx_data;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      txWrPtr <= '0;
      txRdPtr <= '0;
      txCount <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (txPush) txWrPtr <= txWrPtr + 1'b1;
      if (txPop)  txRdPtr <= txRdPtr + 1'b1;
      case ({txPush, txPop})
        2'b10:   txCount <= txCount + 1'b1;
        2'b01:   txCount <= txCount - 1'b1;
        default: txCount <= txCount;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      rxWrPtr <= '0;
      rxRdPtr <= '0;
      rxCount <= '0;
    end else begin
      if (rxPush) rxWrPtr <= rxWrPtr + 1'b1;
      if (rxPop)  rxRdPtr <= rxRdPtr + 1'b1;
      case ({rxPush, rxPop})
        2'b10:   rxCount <= rxCount + 1'b1;
        2'b01:   rxCount <= rxCount - 1'b1;
        default: rxCount <= rxCount;
      endcase
    end
  end

  // Sticky error flags: a new event outranks a simultaneous clear.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
    end else begin
      if (txDrop)             overflowQ <= 1'b1;
      else if (bus.err_clear) overflowQ <= 1'b0;

      if (rxUnder)            underflowQ <= 1'b1;
      else if (bus.err_clear) underflowQ <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_port_unit.sv
module tb_io_port_unit;

  logic CLK = 1'b0;
  logic Reset_n;
  int   nChecks = 0;
  int   nErrors = 0;

  io_port_if #(.WIDTH(16)) bus ();

  io_port_unit #(.WIDTH(16), .DEPTH(4), .PTR_W(2)) dut (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idleInputs();
    bus.OutputWrite  = 1'b0;
    bus.OutData      = '0;
    bus.InputRead    = 1'b0;
    bus.ext_tx_ready = 1'b0;
    bus.ext_rx_data  = '0;
    bus.ext_rx_valid = 1'b0;
    bus.err_clear    = 1'b0;
  endtask

  task automatic txWrite(input logic [15:0] w);
    bus.OutputWrite = 1'b1;
    bus.OutData     = w;
    tick();
    bus.OutputWrite = 1'b0;
  endtask

  logic [15:0] exp4 [4];
  logic [15:0] wrapWords [6];

  initial begin
    idleInputs();
    Reset_n = 1'b0;
    tick();
    tick();

    // Reset state
    checkVal("rst_rx_ready", bus.ext_rx_ready, 0);
    checkVal("rst_tx_valid", bus.ext_tx_valid, 0);
    checkVal("rst_inavail",  bus.InAvail, 0);
    checkVal("rst_outfull",  bus.OutFull, 0);
    checkVal("rst_indata",   bus.InData, 0);
    Reset_n = 1'b1;
    tick();
    checkVal("rel_rx_ready", bus.ext_rx_ready, 1);
    checkVal("rel_inavail",  bus.InAvail, 0);
    checkVal("rel_tx_valid", bus.ext_tx_valid, 0);

    // TX ordering under backpressure
    txWrite(16'h0011);
    checkVal("tx_first_valid", bus.ext_tx_valid, 1);
    checkVal("tx_first_data",  bus.ext_tx_data, 16'h0011);
    txWrite(16'h0022);
    txWrite(16'h0033);
    tick();
    checkVal("tx_hold_valid", bus.ext_tx_valid, 1);
    checkVal("tx_hold_data",  bus.ext_tx_data, 16'h0011);
    bus.ext_tx_ready = 1'b1;
    checkVal("tx_out0", bus.ext_tx_data, 16'h0011);
    tick();
    checkVal("tx_out1", bus.ext_tx_data, 16'h0022);
    tick();
    checkVal("tx_out2", bus.ext_tx_data, 16'h0033);
    tick();
    checkVal("tx_drained", bus.ext_tx_valid, 0);
    bus.ext_tx_ready = 1'b0;

    // TX overflow
    for (int i = 0; i < 4; i++) txWrite(16'h00A0 + 16'(i));
    checkVal("ovf_full",      bus.OutFull, 1);
    checkVal("ovf_not_yet",   bus.OverflowErr, 0);
    txWrite(16'h00A4);
    checkVal("ovf_flag",      bus.OverflowErr, 1);
    checkVal("ovf_head",      bus.ext_tx_data, 16'h00A0);
    bus.ext_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkVal("ovf_drain", bus.ext_tx_data, 16'h00A0 + 16'(i));
      tick();
    end
    checkVal("ovf_empty", bus.ext_tx_valid, 0);
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    checkVal("ovf_cleared", bus.OverflowErr, 0);

    // Pointer wrap with ready held high: each new word is the head next cycle
    wrapWords = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
    for (int i = 0; i < 6; i++) begin
      txWrite(wrapWords[i]);
      checkVal("wrap_head", bus.ext_tx_data, wrapWords[i]);
    end
    tick();
    checkVal("wrap_empty", bus.ext_tx_valid, 0);
    bus.ext_tx_ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) txWrite(16'h00C0 + 16'(i));
    checkVal("fpp_full_before", bus.OutFull, 1);
    bus.ext_tx_ready = 1'b1;
    txWrite(16'hBEEF);
    checkVal("fpp_no_ovf",  bus.OverflowErr, 0);
    checkVal("fpp_full",    bus.OutFull, 1);
    exp4 = '{16'h00C1, 16'h00C2, 16'h00C3, 16'hBEEF};
    for (int i = 0; i < 4; i++) begin
      checkVal("fpp_order", bus.ext_tx_data, exp4[i]);
      tick();
    end
    checkVal("fpp_empty", bus.ext_tx_valid, 0);
    bus.ext_tx_ready = 1'b0;

    // RX path
    bus.ext_rx_valid = 1'b1;
    bus.ext_rx_data  = 16'h1234;
    tick();
    bus.ext_rx_data  = 16'h5678;
    tick();
    bus.ext_rx_valid = 1'b0;
    checkVal("rx_avail", bus.InAvail, 1);
    checkVal("rx_head0", bus.InData, 16'h1234);
    bus.InputRead = 1'b1;
    tick();
    checkVal("rx_head1", bus.InData, 16'h5678);
    tick();
    checkVal("rx_empty_avail", bus.InAvail, 0);
    checkVal("rx_empty_data",  bus.InData, 0);
    checkVal("rx_no_under",    bus.UnderflowErr, 0);
    tick();
    bus.InputRead = 1'b0;
    checkVal("rx_underflow", bus.UnderflowErr, 1);
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    checkVal("rx_under_clr", bus.UnderflowErr, 0);

    // Push and read on empty in the same cycle: no bypass
    bus.ext_rx_valid = 1'b1;
    bus.ext_rx_data  = 16'h7777;
    bus.InputRead    = 1'b1;
    checkVal("nb_indata_zero", bus.InData, 0);
    tick();
    bus.ext_rx_valid = 1'b0;
    bus.InputRead    = 1'b0;
    checkVal("nb_under",  bus.UnderflowErr, 1);
    checkVal("nb_stored", bus.InData, 16'h7777);
    bus.InputRead = 1'b1;
    tick();
    bus.InputRead = 1'b0;
    checkVal("nb_emptied", bus.InAvail, 0);

    // Error clear priority: set wins over clear
    bus.err_clear = 1'b1;
    bus.InputRead = 1'b1;
    tick();
    bus.InputRead = 1'b0;
    checkVal("prio_set_wins", bus.UnderflowErr, 1);
    tick();
    bus.err_clear = 1'b0;
    checkVal("prio_cleared", bus.UnderflowErr, 0);

    // RX full and backpressure on the fifth word
    bus.ext_rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ext_rx_data = 16'h00D0 + 16'(i);
      tick();
    end
    checkVal("rxf_not_ready", bus.ext_rx_ready, 0);
    bus.ext_rx_data = 16'h00D4;
    tick();
    tick();
    checkVal("rxf_still_full", bus.ext_rx_ready, 0);
    checkVal("rxf_head", bus.InData, 16'h00D0);
    bus.InputRead = 1'b1;
    tick();
    bus.InputRead = 1'b0;
    checkVal("rxf_ready_again", bus.ext_rx_ready, 1);
    checkVal("rxf_head1", bus.InData, 16'h00D1);
    tick();
    bus.ext_rx_valid = 1'b0;
    checkVal("rxf_refull", bus.ext_rx_ready, 0);
    for (int i = 1; i < 5; i++) begin
      checkVal("rxf_order", bus.InData, 16'h00D0 + 16'(i));
      bus.InputRead = 1'b1;
      tick();
      bus.InputRead = 1'b0;
    end
    checkVal("rxf_drained", bus.InAvail, 0);

    // Mid-run reset drops in-flight words
    txWrite(16'h0F0F);
    bus.ext_rx_valid = 1'b1;
    bus.ext_rx_data  = 16'hF0F0;
    tick();
    bus.ext_rx_valid = 1'b0;
    txWrite(16'h1111);
    checkVal("mid_pre_tx", bus.ext_tx_valid, 1);
    checkVal("mid_pre_rx", bus.InAvail, 1);
    Reset_n = 1'b0;
    #2;
    checkVal("mid_rst_tx_valid", bus.ext_tx_valid, 0);
    checkVal("mid_rst_inavail",  bus.InAvail, 0);
    checkVal("mid_rst_indata",   bus.InData, 0);
    checkVal("mid_rst_rx_ready", bus.ext_rx_ready, 0);
    checkVal("mid_rst_outfull",  bus.OutFull, 0);
    tick();
    Reset_n = 1'b1;
    tick();
    checkVal("mid_rel_rx_ready", bus.ext_rx_ready, 1);
    checkVal("mid_rel_tx_valid", bus.ext_tx_valid, 0);
    checkVal("mid_rel_inavail",  bus.InAvail, 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
